// File: rtl/exec_stage.sv
// Execute/writeback stage: single-cycle ALU plus a MUL_LAT-deep multiply pipe
// sharing one writeback/wakeup broadcast port (multiply has priority).
module exec_stage #(
    parameter int MUL_LAT = 3,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_opcode,
    input  logic [TAG_W-1:0]  issue_dest_prf,
    input  logic [DATA_W-1:0] src1_data,
    input  logic [DATA_W-1:0] src2_data,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_dest_prf,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_cnt
);

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_XOR = 5'b00110;
    localparam logic [4:0] OP_SLL = 5'b00111;
    localparam logic [4:0] OP_SRL = 5'b01000;

    logic              alu_v_q, alu_v_d;
    logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d;

    logic [MUL_LAT-1:0] mul_v_q, mul_v_d;
    logic [TAG_W-1:0]   mul_tag_q [MUL_LAT];
    logic [TAG_W-1:0]   mul_tag_d [MUL_LAT];
    logic [DATA_W-1:0]  mul_data_q [MUL_LAT];
    logic [DATA_W-1:0]  mul_data_d [MUL_LAT];

    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              mul_out_v;
    logic              accept;
    logic              is_mul;
    logic              ready_next;
    logic [DATA_W-1:0] alu_calc;
    logic [DATA_W-1:0] mul_calc;

    assign mul_out_v   = mul_v_q[MUL_LAT-1];
    assign issue_ready = !(alu_v_q && mul_out_v);
    assign is_mul      = (issue_opcode == OP_MUL);
    assign accept      = issue_valid && issue_ready;
    assign mul_calc    = src1_data * src2_data;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        alu_calc = '0;
        case (issue_opcode)
            OP_ADD:  alu_calc = src1_data + src2_data;
            OP_SUB:  alu_calc = src1_data - src2_data;
            OP_AND:  alu_calc = src1_data & src2_data;
            OP_OR:   alu_calc = src1_data | src2_data;
            OP_XOR:  alu_calc = src1_data ^ src2_data;
            OP_SLL:  alu_calc = src1_data << src2_data[4:0];
            OP_SRL:  alu_calc = src1_data >> src2_data[4:0];
            default: alu_calc = '0;
        endcase
    end

    always_comb begin
        mul_v_d       = {mul_v_q[MUL_LAT-2:0], accept && is_mul};
        mul_tag_d[0]  = issue_dest_prf;
        mul_data_d[0] = mul_calc;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_tag_d[i]  = mul_tag_q[i-1];
            mul_data_d[i] = mul_data_q[i-1];
        end

        // ALU register drains when it wins the port, holds when MUL wins.
        alu_v_d    = alu_v_q && mul_out_v;
        alu_dest_d = alu_dest_q;
        alu_res_d  = alu_res_q;
        if (accept && !is_mul) begin
            alu_v_d    = 1'b1;
            alu_dest_d = issue_dest_prf;
            alu_res_d  = alu_calc;
        end

        // Counting against next-cycle readiness makes the count already
        // include the stalled cycle while it is being observed.
        ready_next  = !(alu_v_d && mul_v_d[MUL_LAT-1]);
        stall_cnt_d = stall_cnt_q;
        if (!ready_next && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        wb_valid    = 1'b0;
        wb_dest_prf = '0;
        wb_data     = '0;
        if (mul_out_v) begin
            wb_valid    = 1'b1;
            wb_dest_prf = mul_tag_q[MUL_LAT-1];
            wb_data     = mul_data_q[MUL_LAT-1];
        end else if (alu_v_q) begin
            wb_valid    = 1'b1;
            wb_dest_prf = alu_dest_q;
            wb_data     = alu_res_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_v_q     <= 1'b0;
            alu_dest_q  <= '0;
            alu_res_q   <= '0;
            mul_v_q     <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_tag_q[i]  <= '0;
                mul_data_q[i] <= '0;
            end
        end else begin
            alu_v_q     <= alu_v_d;
            alu_dest_q  <= alu_dest_d;
            alu_res_q   <= alu_res_d;
            mul_v_q     <= mul_v_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_tag_q[i]  <= mul_tag_d[i];
                mul_data_q[i] <= mul_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: a scheduled-writeback model checked every
// cycle, plus literal expectations from hand calculation.
module tb_exec_stage;

    localparam int MUL_LAT = 3;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [4:0]        issue_opcode = 5'd0;
    logic [TAG_W-1:0]  issue_dest_prf = '0;
    logic [DATA_W-1:0] src1_data = '0;
    logic [DATA_W-1:0] src2_data = '0;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_dest_prf;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    exec_stage #(.MUL_LAT(MUL_LAT), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_dest_prf(issue_dest_prf),
        .src1_data(src1_data), .src2_data(src2_data),
        .wb_valid(wb_valid), .wb_dest_prf(wb_dest_prf), .wb_data(wb_data),
        .stall_cnt(stall_cnt)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // behavioural model: pending multiplies carry the cycle they are due,
    // ALU results wait in a single slot until the port is free.
    typedef struct {
        int                cyc_due;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } mul_ent_t;

    mul_ent_t          exp_q[$];
    int                cyc = 0;
    bit                alu_pend = 1'b0;
    logic [TAG_W-1:0]  alu_tag = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic [15:0]       exp_stall = '0;

    function automatic logic [DATA_W-1:0] ref_op(input logic [4:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a * b;
            5'd4:    return a & b;
            5'd5:    return a | b;
            5'd6:    return a ^ b;
            5'd7:    return a << sh;
            5'd8:    return a >> sh;
            default: return '0;
        endcase
    endfunction

    function automatic bit mul_due_now();
        return (exp_q.size() > 0) && (exp_q[0].cyc_due == cyc);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            alu_pend = 1'b0;
            cyc      = 0;
        end else begin
            bit md;
            bit rdy;
            md  = mul_due_now();
            rdy = !(alu_pend && md);
            if (md) void'(exp_q.pop_front());
            else if (alu_pend) alu_pend = 1'b0;
            cyc++;
            if (issue_valid && rdy) begin
                if (issue_opcode == 5'd3) begin
                    exp_q.push_back('{cyc + MUL_LAT - 1, issue_dest_prf,
                                      ref_op(issue_opcode, src1_data, src2_data)});
                end else begin
                    alu_pend = 1'b1;
                    alu_tag  = issue_dest_prf;
                    alu_data = ref_op(issue_opcode, src1_data, src2_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, once per cycle on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            exp_stall = '0;
            chk("rst_ready", {31'd0, issue_ready}, 32'd1);
            chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("rst_wb_tag", {26'd0, wb_dest_prf}, 32'd0);
            chk("rst_wb_data", wb_data, 32'd0);
            chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        end else begin
            bit md;
            bit rdy;
            md  = mul_due_now();
            rdy = !(alu_pend && md);
            if (!rdy && exp_stall != 16'hFFFF) exp_stall++;
            chk("ready", {31'd0, issue_ready}, {31'd0, rdy});
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, md || alu_pend});
            if (md) begin
                chk("wb_tag_mul", {26'd0, wb_dest_prf}, {26'd0, exp_q[0].tag});
                chk("wb_data_mul", wb_data, exp_q[0].data);
            end else if (alu_pend) begin
                chk("wb_tag_alu", {26'd0, wb_dest_prf}, {26'd0, alu_tag});
                chk("wb_data_alu", wb_data, alu_data);
            end
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
        end
    end

    // driver: inputs change 1 time unit after the falling edge
    task automatic drive(input logic v, input logic [4:0] op, input logic [TAG_W-1:0] d,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        @(negedge clk);
        #1;
        issue_valid    = v;
        issue_opcode   = op;
        issue_dest_prf = d;
        src1_data      = a;
        src2_data      = b;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, '0, '0);
    endtask

    task automatic lit_wb(input string name, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] data);
        chk({name, "_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({name, "_tag"}, {26'd0, wb_dest_prf}, {26'd0, tag});
        chk({name, "_data"}, wb_data, data);
    endtask

    initial begin
        // reset held with a request pending: nothing accepted
        issue_valid = 1'b1; issue_opcode = 5'd1; issue_dest_prf = 6'd9;
        src1_data = 32'd1; src2_data = 32'd2;
        repeat (3) begin
            @(negedge clk); #1;
            chk("lit_rst_ready", {31'd0, issue_ready}, 32'd1);
            chk("lit_rst_valid", {31'd0, wb_valid}, 32'd0);
        end
        issue_valid = 1'b0;
        reset = 1'b1;
        idle();
        chk("lit_post_rst_valid", {31'd0, wb_valid}, 32'd0);

        // back-to-back ALU ops
        drive(1'b1, 5'd1, 6'd10, 32'd10, 32'd20);
        drive(1'b1, 5'd2, 6'd12, 32'd10, 32'd20);
        lit_wb("lit_add", 6'd10, 32'd30);
        drive(1'b1, 5'd7, 6'd13, 32'd1, 32'd35);
        lit_wb("lit_sub", 6'd12, 32'hFFFF_FFF6);
        idle();
        lit_wb("lit_sll", 6'd13, 32'd8);
        idle();

        // four MULs on consecutive edges
        drive(1'b1, 5'd3, 6'd11, 32'd10, 32'd20);
        drive(1'b1, 5'd3, 6'd14, 32'd3, 32'd4);
        drive(1'b1, 5'd3, 6'd15, 32'hFFFF_FFFF, 32'd2);
        chk("lit_mul_not_yet", {31'd0, wb_valid}, 32'd0);
        drive(1'b1, 5'd3, 6'd16, 32'd7, 32'd7);
        lit_wb("lit_mul0", 6'd11, 32'd200);
        idle();
        lit_wb("lit_mul1", 6'd14, 32'd12);
        idle();
        lit_wb("lit_mul2", 6'd15, 32'hFFFF_FFFE);
        idle();
        lit_wb("lit_mul3", 6'd16, 32'd49);
        chk("lit_no_stall", {16'd0, stall_cnt}, 32'd0);
        repeat (2) idle();

        // collision: MUL at E, ADD at E+2, XOR held through the stall
        drive(1'b1, 5'd3, 6'd11, 32'd10, 32'd20);
        idle();
        drive(1'b1, 5'd1, 6'd10, 32'd10, 32'd20);
        drive(1'b1, 5'd6, 6'd20, 32'h0000_F0F0, 32'h0000_FF00);
        lit_wb("lit_col_mul", 6'd11, 32'd200);
        chk("lit_col_ready", {31'd0, issue_ready}, 32'd0);
        chk("lit_col_stall", {16'd0, stall_cnt}, 32'd1);
        drive(1'b1, 5'd6, 6'd20, 32'h0000_F0F0, 32'h0000_FF00);
        lit_wb("lit_col_alu", 6'd10, 32'd30);
        chk("lit_col_ready2", {31'd0, issue_ready}, 32'd1);
        idle();
        lit_wb("lit_xor", 6'd20, 32'h0000_0FF0);

        // remaining logic ops
        drive(1'b1, 5'd4, 6'd21, 32'hF0F0_1234, 32'h0FF0_FFFF);
        drive(1'b1, 5'd5, 6'd22, 32'hF000_0000, 32'h0000_000F);
        drive(1'b1, 5'd8, 6'd23, 32'h8000_0000, 32'd31);
        lit_wb("lit_or", 6'd22, 32'hF000_000F);
        idle();
        lit_wb("lit_srl", 6'd23, 32'd1);
        repeat (2) idle();

        // reset while a MUL is in flight
        drive(1'b1, 5'd3, 6'd7, 32'd3, 32'd3);
        @(negedge clk); #1;
        issue_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        repeat (5) begin
            idle();
            chk("lit_flush_valid", {31'd0, wb_valid}, 32'd0);
        end

        // undefined opcode still broadcasts its tag
        drive(1'b1, 5'b11111, 6'd5, 32'd123, 32'd456);
        idle();
        lit_wb("lit_undef", 6'd5, 32'd0);
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
